uart_job_loader: RTL and testbench

Byte-stream command front-end between a UART rx/tx byte pair and a nonce-search hash core. It parses handshake and reset commands, assembles a parametrised job frame (data, midstate, target, nonce base, position), and launches the core. It returns the found nonce to the host, and supports an inter-byte timeout and host abort. It generalises the fixed 136-byte loader to arbitrary field widths and adds strict framing.

---
 rtl/uart_job_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_job_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_job_loader.sv
// Byte-stream command front-end: parses host commands, assembles a job frame for the hash core,
// and returns the found nonce. Define UART_JOB_CSUM_EN to require a trailing XOR checksum byte.
module uart_job_loader #(
    parameter int DATA_BYTES     = 64,
    parameter int STATE_BYTES    = 32,
    parameter int TARGET_BYTES   = 32,
    parameter int NONCE_BYTES    = 4,
    parameter int POS_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      rx_ready,
    output logic                      tx_valid,
    output logic [7:0]                tx_data,
    input  logic                      tx_ready,
    output logic                      core_rst,
    output logic                      job_valid,
    output logic [8*DATA_BYTES-1:0]   job_data,
    output logic [8*STATE_BYTES-1:0]  job_state,
    output logic [8*TARGET_BYTES-1:0] job_target,
    output logic [8*NONCE_BYTES-1:0]  job_nonce,
    output logic [8*POS_BYTES-1:0]    job_pos,
    input  logic                      res_valid,
    input  logic [8*NONCE_BYTES-1:0]  res_nonce
);

    localparam int PAYLOAD_BYTES = DATA_BYTES + STATE_BYTES + TARGET_BYTES + NONCE_BYTES + POS_BYTES;
`ifdef UART_JOB_CSUM_EN
    localparam int FRAME_BYTES = PAYLOAD_BYTES + 1;
`else
    localparam int FRAME_BYTES = PAYLOAD_BYTES;
`endif
    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int IDX_W = $clog2(NONCE_BYTES + 2);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] IDX_DONE  = IDX_W'(NONCE_BYTES + 1);

    localparam int OFF_STATE  = 8 * DATA_BYTES;
    localparam int OFF_TARGET = OFF_STATE + 8 * STATE_BYTES;
    localparam int OFF_NONCE  = OFF_TARGET + 8 * TARGET_BYTES;
    localparam int OFF_POS    = OFF_NONCE + 8 * NONCE_BYTES;

    localparam logic [7:0] CMD_RESET = "R";
    localparam logic [7:0] CMD_HELLO = "H";
    localparam logic [7:0] CMD_ABORT = "A";
    localparam logic [7:0] REP_OK    = "O";
    localparam logic [7:0] REP_HELLO = "1";
    localparam logic [7:0] REP_BAD   = "E";
    localparam logic [7:0] REP_START = "S";
    localparam logic [7:0] REP_FOUND = "Y";
    localparam logic [7:0] REP_ABORT = "X";
    localparam logic [7:0] REP_BUSY  = "e";
    localparam logic [7:0] REP_TOUT  = "T";
    localparam logic [7:0] REP_CSUM  = "C";

    typedef enum logic [1:0] {IDLE, RECV, HASH, SEND} state_t;

    state_t                     state_q, state_d;
    logic                       tx_valid_d, core_rst_d, job_valid_d;
    logic [7:0]                 tx_data_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [8*NONCE_BYTES-1:0]   nonce_q, nonce_d;
    logic [8*PAYLOAD_BYTES-1:0] frame_q;
    logic                       byte_we, csum_ok, rx_fire;
`ifdef UART_JOB_CSUM_EN
    logic [7:0]                 csum_q, csum_d;
`endif

    // Replies are never dropped: no new byte is taken while one is waiting to go out.
    assign rx_ready = !tx_valid && (state_q != SEND);
    assign rx_fire  = rx_valid && rx_ready;

    assign job_data   = frame_q[0 +: 8*DATA_BYTES];
    assign job_state  = frame_q[OFF_STATE +: 8*STATE_BYTES];
    assign job_target = frame_q[OFF_TARGET +: 8*TARGET_BYTES];
    assign job_nonce  = frame_q[OFF_NONCE +: 8*NONCE_BYTES];
    assign job_pos    = frame_q[OFF_POS +: 8*POS_BYTES];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        tx_valid_d  = tx_valid && !tx_ready;
        tx_data_d   = tx_data;
        core_rst_d  = core_rst;
        job_valid_d = 1'b0;
        cnt_d       = cnt_q;
        to_cnt_d    = to_cnt_q;
        idx_d       = idx_q;
        nonce_d     = nonce_q;
        byte_we     = 1'b0;
        csum_ok     = 1'b1;
`ifdef UART_JOB_CSUM_EN
        csum_d      = csum_q;
        csum_ok     = (rx_data == csum_q);
`endif

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    tx_valid_d = 1'b1;
                    case (rx_data)
                        CMD_RESET: tx_data_d = REP_OK;
                        CMD_HELLO: begin
                            tx_data_d  = REP_HELLO;
                            core_rst_d = 1'b0;
                            cnt_d      = '0;
                            to_cnt_d   = '0;
                            state_d    = RECV;
`ifdef UART_JOB_CSUM_EN
                            csum_d     = '0;
`endif
                        end
                        default:   tx_data_d = REP_BAD;
                    endcase
                end
            end

            RECV: begin
                if (rx_fire) begin
                    to_cnt_d = '0;
                    cnt_d    = cnt_q + CNT_W'(1);
                    byte_we  = 1'b1;
`ifdef UART_JOB_CSUM_EN
                    csum_d   = csum_q ^ rx_data;
`endif
                    if (cnt_q == LAST_BYTE) begin
                        cnt_d      = '0;
                        tx_valid_d = 1'b1;
                        if (csum_ok) begin
                            tx_data_d   = REP_START;
                            job_valid_d = 1'b1;
                            state_d     = HASH;
                        end else begin
                            tx_data_d  = REP_CSUM;
                            core_rst_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    // Saturate while a reply is still draining, then fire on the first free slot.
                    if (to_cnt_q != TO_MAX) begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end else if (!tx_valid) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = REP_TOUT;
                        core_rst_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end

            HASH: begin
                if (rx_fire && (rx_data == CMD_ABORT || rx_data == CMD_RESET)) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = (rx_data == CMD_ABORT) ? REP_ABORT : REP_OK;
                    core_rst_d = 1'b1;
                    state_d    = IDLE;
                end else if (res_valid) begin
                    nonce_d = res_nonce;
                    state_d = SEND;
                    if (!tx_valid_d) begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = REP_FOUND;
                        idx_d      = IDX_W'(1);
                    end else begin
                        idx_d = '0;
                    end
                end else if (rx_fire) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = REP_BUSY;
                end
            end

            SEND: begin
                // idx 0 is the 'Y' marker, 1..NONCE_BYTES are nonce bytes LSB first.
                if (idx_q == IDX_DONE) begin
                    if (!tx_valid_d) begin
                        core_rst_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (!tx_valid_d) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = (idx_q == '0) ? REP_FOUND
                                               : nonce_q[{idx_q - IDX_W'(1), 3'b000} +: 8];
                    idx_d      = idx_q + IDX_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            core_rst  <= 1'b1;
            job_valid <= 1'b0;
            cnt_q     <= '0;
            to_cnt_q  <= '0;
            idx_q     <= '0;
            nonce_q   <= '0;
            // NOTE: the frame store is reset because job fields must read 0 after reset.
            frame_q   <= '0;
`ifdef UART_JOB_CSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tx_valid  <= tx_valid_d;
            tx_data   <= tx_data_d;
            core_rst  <= core_rst_d;
            job_valid <= job_valid_d;
            cnt_q     <= cnt_d;
            to_cnt_q  <= to_cnt_d;
            idx_q     <= idx_d;
            nonce_q   <= nonce_d;
`ifdef UART_JOB_CSUM_EN
            csum_q    <= csum_d;
`endif
            // The checksum byte index matches no payload slot, so it is never stored.
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                if (byte_we && cnt_q == CNT_W'(i)) frame_q[8*i +: 8] <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_job_loader.sv
// Self-checking bench for uart_job_loader: table-driven IDLE commands plus directed
// sequences for framing, result return, timeout, abort race and mid-frame reset.
module tb_uart_job_loader;

    localparam int TO  = 1000;
    localparam int PAY = 136;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = '0;
    logic         rx_ready;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic         tx_ready = 1'b1;
    logic         core_rst;
    logic         job_valid;
    logic [511:0] job_data;
    logic [255:0] job_state;
    logic [255:0] job_target;
    logic [31:0]  job_nonce;
    logic [31:0]  job_pos;
    logic         res_valid = 1'b0;
    logic [31:0]  res_nonce = '0;

    uart_job_loader #(
        .DATA_BYTES(64), .STATE_BYTES(32), .TARGET_BYTES(32),
        .NONCE_BYTES(4), .POS_BYTES(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .core_rst(core_rst), .job_valid(job_valid),
        .job_data(job_data), .job_state(job_state), .job_target(job_target),
        .job_nonce(job_nonce), .job_pos(job_pos),
        .res_valid(res_valid), .res_nonce(res_nonce)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         jv_count = 0;
    logic [7:0] tx_q[$];

    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (job_valid) jv_count++;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] reply;
        logic       core_rst;
    } idle_vec_t;

    idle_vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_valid = 1'b1;
        k = 0;
        while (!rx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!rx_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_byte: rx_ready stuck low, byte %0h not accepted", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_tx(input string name, input logic [7:0] exp);
        int k;
        k = 0;
        while (tx_q.size() == 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (tx_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no reply byte, expected %0h", name, exp);
        end else begin
            check(name, tx_q.pop_front(), exp);
        end
    endtask

    task automatic send_payload();
        for (int i = 0; i < PAY; i++) send_byte(8'(i));
    endtask

    task automatic wait_rx_ready();
        int k;
        k = 0;
        while (!rx_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rx_ready_free", rx_ready, 1'b1);
    endtask

`ifdef UART_JOB_CSUM_EN
    logic [7:0] exp_csum;
`endif

    initial begin
        int k;
        vecs[0] = '{cmd: "Q", reply: "E", core_rst: 1'b1};
        vecs[1] = '{cmd: "R", reply: "O", core_rst: 1'b1};
        vecs[2] = '{cmd: "Z", reply: "E", core_rst: 1'b1};
        vecs[3] = '{cmd: "A", reply: "E", core_rst: 1'b1};
`ifdef UART_JOB_CSUM_EN
        exp_csum = '0;
        for (int i = 0; i < PAY; i++) exp_csum = exp_csum ^ 8'(i);
`endif

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_core_rst", core_rst, 1'b1);
        check("rst_job_valid", job_valid, 1'b0);
        check("rst_job_pos", job_pos, 32'h0);
        check("rst_job_data", job_data[63:0], 64'h0);
        rstn = 1'b1;
        @(negedge clk);

        // IDLE command table
        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].cmd);
            expect_tx($sformatf("idle_reply_%0d", i), vecs[i].reply);
            check($sformatf("idle_core_rst_%0d", i), core_rst, vecs[i].core_rst);
        end

        // Full frame and launch
        send_byte("H");
        expect_tx("hs_reply", "1");
        check("hs_core_rst", core_rst, 1'b0);
        send_payload();
`ifdef UART_JOB_CSUM_EN
        send_byte(exp_csum);
`endif
        expect_tx("launch_reply", "S");
        repeat (2) @(negedge clk);
        check("launch_pulses", jv_count, 1);
        check("job_data_lo", job_data[7:0], 8'h00);
        check("job_data_hi", job_data[511:504], 8'h3f);
        check("job_state_lo", job_state[7:0], 8'h40);
        check("job_target_lo", job_target[7:0], 8'h60);
        check("job_nonce", job_nonce, 32'h83828180);
        check("job_pos", job_pos, 32'h87868584);

        send_byte("Q");
        expect_tx("hash_junk", "e");

        // Result with tx backpressure on the 'Y'
        wait_rx_ready();
        tx_ready  = 1'b0;
        res_nonce = 32'hDEADBEEF;
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        check("y_latency", tx_valid, 1'b1);
        repeat (4) @(negedge clk);
        check("y_held_valid", tx_valid, 1'b1);
        check("y_held_data", tx_data, "Y");
        check("send_rx_ready", rx_ready, 1'b0);
        tx_ready = 1'b1;
        expect_tx("res_y", "Y");
        expect_tx("res_b0", 8'hEF);
        expect_tx("res_b1", 8'hBE);
        expect_tx("res_b2", 8'hAD);
        expect_tx("res_b3", 8'hDE);
        repeat (3) @(negedge clk);
        check("send_done_core_rst", core_rst, 1'b1);
        check("send_no_extra", tx_q.size(), 0);
        send_byte("R");
        expect_tx("after_send_idle", "O");

        // Inter-byte timeout
        send_byte("H");
        expect_tx("to_hs", "1");
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        k = 0;
        while (!tx_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", k, TO + 1);
        expect_tx("timeout_reply", "T");
        check("timeout_core_rst", core_rst, 1'b1);
        send_byte("Z");
        expect_tx("after_timeout", "E");

        // Abort in the same cycle as res_valid
        send_byte("H");
        expect_tx("ab_hs", "1");
        send_payload();
`ifdef UART_JOB_CSUM_EN
        send_byte(exp_csum);
`endif
        expect_tx("ab_launch", "S");
        wait_rx_ready();
        rx_data   = "A";
        rx_valid  = 1'b1;
        res_nonce = 32'h12345678;
        res_valid = 1'b1;
        @(negedge clk);
        rx_valid  = 1'b0;
        res_valid = 1'b0;
        expect_tx("abort_reply", "X");
        repeat (10) @(negedge clk);
        check("abort_no_y", tx_q.size(), 0);
        check("abort_core_rst", core_rst, 1'b1);
        check("abort_launches", jv_count, 2);

`ifdef UART_JOB_CSUM_EN
        // Corrupted checksum
        send_byte("H");
        expect_tx("cs_hs", "1");
        send_payload();
        send_byte(exp_csum ^ 8'h01);
        expect_tx("csum_reply", "C");
        repeat (2) @(negedge clk);
        check("csum_no_launch", jv_count, 2);
        check("csum_core_rst", core_rst, 1'b1);
`endif

        // Reset in the middle of a frame
        send_byte("H");
        expect_tx("mr_hs", "1");
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
        rstn = 1'b0;
        #1;
        check("mr_tx_valid", tx_valid, 1'b0);
        check("mr_tx_data", tx_data, 8'h00);
        check("mr_rx_ready", rx_ready, 1'b1);
        check("mr_core_rst", core_rst, 1'b1);
        check("mr_job_valid", job_valid, 1'b0);
        check("mr_job_data", job_data[63:0], 64'h0);
        check("mr_job_pos", job_pos, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send_byte("R");
        expect_tx("mr_idle", "O");
        check("mr_no_extra", tx_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
